// File: rtl/pulse_width_meter_if.sv
// Measurement bus of pulse_width_meter: the pulse input plus the reported
// high/low widths, saturation flags, strobes, busy and an FSM debug view.
interface pulse_width_meter_if #(parameter int CNT_W = 8);
  logic             sig;
  logic [CNT_W-1:0] hi_width;
  logic             hi_valid;
  logic             hi_sat;
  logic [CNT_W-1:0] lo_width;
  logic             lo_valid;
  logic             lo_sat;
  logic             busy;
  logic [1:0]       state_dbg;

  // Strobe semantics: *_valid is high for exactly one cycle when the matching
  // *_width/*_sat pair changes; the pair then holds until the next strobe.
  // There is no ready: the consumer must capture the value on the strobe.
  modport master (
    input  sig,
    output hi_width, hi_valid, hi_sat,
    output lo_width, lo_valid, lo_sat,
    output busy, state_dbg
  );

  modport slave (
    output sig,
    input  hi_width, hi_valid, hi_sat,
    input  lo_width, lo_valid, lo_sat,
    input  busy, state_dbg
  );
endinterface

// File: rtl/pulse_width_meter.sv
// Measures high and low interval lengths of sig in clk cycles, saturating at 2**CNT_W-1.
// Define PWM_METER_SYNC_EN to pass sig through a 2-flop synchronizer first.
module pulse_width_meter #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pulse_width_meter_if.master  bus
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] hi_width_q, hi_width_d;
  logic [CNT_W-1:0] lo_width_q, lo_width_d;
  logic             hi_valid_q, hi_valid_d;
  logic             lo_valid_q, lo_valid_d;
  logic             hi_sat_q, hi_sat_d;
  logic             lo_sat_q, lo_sat_d;
  logic             busy_q, busy_d;
  logic             s_q, s_d;
  logic             s, rise, fall;

`ifdef PWM_METER_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  assign s = sync2_q;
`else
  assign s = bus.sig;
`endif

  assign rise = s & ~s_q;
  assign fall = ~s & s_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_width_d = hi_width_q;
    hi_sat_d   = hi_sat_q;
    lo_width_d = lo_width_q;
    lo_sat_d   = lo_sat_q;
    hi_valid_d = 1'b0;
    lo_valid_d = 1'b0;
    s_d        = s;
`ifdef PWM_METER_SYNC_EN
    sync1_d    = bus.sig;
    sync2_d    = sync1_q;
`endif
    cnt_inc    = (cnt_q == MAX) ? cnt_q : cnt_q + ONE;

    // The counter sticks at MAX, so "saturated" is simply cnt == MAX at the edge.
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          hi_width_d = cnt_q;
          hi_sat_d   = (cnt_q == MAX);
          hi_valid_d = 1'b1;
          state_d    = LOW;
          cnt_d      = ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOW: begin
        if (rise) begin
          lo_width_d = cnt_q;
          lo_sat_d   = (cnt_q == MAX);
          lo_valid_d = 1'b1;
          state_d    = HIGH;
          cnt_d      = ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // s_q (and the synchronizer) reset high so a level already high at release is not a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_width_q <= '0;
      hi_sat_q   <= 1'b0;
      hi_valid_q <= 1'b0;
      lo_width_q <= '0;
      lo_sat_q   <= 1'b0;
      lo_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      s_q        <= 1'b1;
`ifdef PWM_METER_SYNC_EN
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_width_q <= hi_width_d;
      hi_sat_q   <= hi_sat_d;
      hi_valid_q <= hi_valid_d;
      lo_width_q <= lo_width_d;
      lo_sat_q   <= lo_sat_d;
      lo_valid_q <= lo_valid_d;
      busy_q     <= busy_d;
      s_q        <= s_d;
`ifdef PWM_METER_SYNC_EN
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
`endif
    end
  end

  assign bus.hi_width  = hi_width_q;
  assign bus.hi_valid  = hi_valid_q;
  assign bus.hi_sat    = hi_sat_q;
  assign bus.lo_width  = lo_width_q;
  assign bus.lo_valid  = lo_valid_q;
  assign bus.lo_sat    = lo_sat_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: an 8-bit and a 4-bit instance share sig/rst and are
// checked every cycle against a run-length model, plus literal scenario expectations.
module tb_pulse_width_meter;

`ifdef PWM_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef logic [8:0] ent_t;      // {sat, width zero-extended to 8 bits}
  typedef ent_t       ent_q_t[$];

  logic clk = 1'b0;
  logic rst;
  logic sig;

  always #5 clk = ~clk;

  pulse_width_meter_if #(.CNT_W(8)) bus8 ();
  pulse_width_meter_if #(.CNT_W(4)) bus4 ();

  assign bus8.sig = sig;
  assign bus4.sig = sig;

  pulse_width_meter #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  pulse_width_meter #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // ---------------- behavioural model: run lengths of the sampled level ----------------
  int   max_v[2] = '{255, 15};
  bit   m_lvl;
  int   m_len;
  bit   m_armed;
  bit   m_p0, m_p1;
  bit   e_busy;
  bit   e_hi_v[2], e_hi_s[2], e_lo_v[2], e_lo_s[2];
  logic [7:0] e_hi_w[2], e_lo_w[2];

  // A run is reported once it ends, but only runs starting at or after the first
  // genuine rise since reset; before reset release the level counts as high.
  task automatic model_step();
    bit smp;
    int w;
    if (rst) begin
      m_lvl = 1'b1; m_len = 0; m_armed = 1'b0; m_p0 = 1'b1; m_p1 = 1'b1;
      e_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e_hi_v[i] = 0; e_hi_s[i] = 0; e_hi_w[i] = '0;
        e_lo_v[i] = 0; e_lo_s[i] = 0; e_lo_w[i] = '0;
      end
    end else begin
`ifdef PWM_METER_SYNC_EN
      smp  = m_p1;
      m_p1 = m_p0;
      m_p0 = sig;
`else
      smp  = sig;
`endif
      for (int i = 0; i < 2; i++) begin
        e_hi_v[i] = 0;
        e_lo_v[i] = 0;
      end
      if (smp != m_lvl) begin
        if (m_armed) begin
          for (int i = 0; i < 2; i++) begin
            w = (m_len >= max_v[i]) ? max_v[i] : m_len;
            if (m_lvl) begin
              e_hi_v[i] = 1; e_hi_w[i] = 8'(w); e_hi_s[i] = (m_len >= max_v[i]);
            end else begin
              e_lo_v[i] = 1; e_lo_w[i] = 8'(w); e_lo_s[i] = (m_len >= max_v[i]);
            end
          end
        end
        if (smp) m_armed = 1'b1;
        m_lvl = smp;
        m_len = 1;
      end else begin
        m_len++;
      end
      e_busy = m_armed;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- scoreboard: strobe logs and expected queues ----------------
  ent_q_t obs_hi8, obs_lo8, obs_hi4, obs_lo4;
  ent_q_t exp_hi8_q, exp_lo8_q, exp_hi4_q, exp_lo4_q;
  int     hi_cyc8[$];

  task automatic cmp_vec(input string name, input logic [20:0] got, input logic [20:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic check_lit(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_q(input string name, input ent_q_t obs, input ent_q_t exp);
    n_chk++;
    if (obs.size() != exp.size()) begin
      n_fail++;
      $display("FAIL %s strobe count: got %0d expected %0d", name, obs.size(), exp.size());
    end else begin
      foreach (obs[i]) begin
        n_chk++;
        if (obs[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL %s entry %0d: got sat/width %h expected %h", name, i, obs[i], exp[i]);
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    cmp_vec("dut8 outputs",
            {bus8.busy, bus8.hi_valid, bus8.hi_sat, bus8.hi_width,
             bus8.lo_valid, bus8.lo_sat, bus8.lo_width},
            {e_busy, e_hi_v[0], e_hi_s[0], e_hi_w[0], e_lo_v[0], e_lo_s[0], e_lo_w[0]});
    cmp_vec("dut4 outputs",
            {bus4.busy, bus4.hi_valid, bus4.hi_sat, 4'b0, bus4.hi_width,
             bus4.lo_valid, bus4.lo_sat, 4'b0, bus4.lo_width},
            {e_busy, e_hi_v[1], e_hi_s[1], e_hi_w[1], e_lo_v[1], e_lo_s[1], e_lo_w[1]});
    if (bus8.hi_valid) begin
      obs_hi8.push_back({bus8.hi_sat, bus8.hi_width});
      hi_cyc8.push_back(cyc);
    end
    if (bus8.lo_valid) obs_lo8.push_back({bus8.lo_sat, bus8.lo_width});
    if (bus4.hi_valid) obs_hi4.push_back({bus4.hi_sat, 4'b0, bus4.hi_width});
    if (bus4.lo_valid) obs_lo4.push_back({bus4.lo_sat, 4'b0, bus4.lo_width});
  end

  // ---------------- driver tasks ----------------
  task automatic clear_q();
    obs_hi8.delete(); obs_lo8.delete(); obs_hi4.delete(); obs_lo4.delete();
    exp_hi8_q.delete(); exp_lo8_q.delete(); exp_hi4_q.delete(); exp_lo4_q.delete();
    hi_cyc8.delete();
  endtask

  task automatic set_sig(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      sig = v;
    end
  endtask

  task automatic do_reset(input logic v);
    @(negedge clk);
    #1;
    rst = 1'b1;
    sig = v;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    clear_q();
  endtask

  function automatic ent_t clip(input int len, input int mx);
    return (len >= mx) ? {1'b1, 8'(mx)} : {1'b0, 8'(len)};
  endfunction

  task automatic push_hi(input int len);
    exp_hi8_q.push_back(clip(len, 255));
    exp_hi4_q.push_back(clip(len, 15));
  endtask

  task automatic push_lo(input int len);
    exp_lo8_q.push_back(clip(len, 255));
    exp_lo4_q.push_back(clip(len, 15));
  endtask

  task automatic end_scn(input string name);
    repeat (4) @(negedge clk);
    #1;
    check_q({name, " hi8"}, obs_hi8, exp_hi8_q);
    check_q({name, " lo8"}, obs_lo8, exp_lo8_q);
    check_q({name, " hi4"}, obs_hi4, exp_hi4_q);
    check_q({name, " lo4"}, obs_lo4, exp_lo4_q);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fall_cyc;
    logic lvl;
    int len;

    rst = 1'b0;
    sig = 1'b0;
    #1 rst = 1'b1;

    // Basic 3-high / 2-low / 3-high sequence and strobe latency.
    do_reset(1'b0);
    check_lit("reset busy", int'(bus8.busy), 0);
    check_lit("reset state", int'(bus8.state_dbg), 0);
    set_sig(1'b0, 2);
    set_sig(1'b1, 3);
    set_sig(1'b0, 1);
    fall_cyc = cyc;
    set_sig(1'b0, 1);
    set_sig(1'b1, 3);
    set_sig(1'b0, 4);
    push_hi(3); push_lo(2); push_hi(3);
    end_scn("basic");
    check_lit("basic hi strobe latency", (hi_cyc8.size() > 0) ? hi_cyc8[0] - fall_cyc : -1, 1 + LAT);

    // High through reset release: partial pulse and the following low are discarded.
    do_reset(1'b1);
    set_sig(1'b1, 3);
    set_sig(1'b0, 4);
    set_sig(1'b1, 2);
    set_sig(1'b0, 3);
    push_hi(2);
    end_scn("partial");

    // Saturation: 20 and 300 clip on the 4-bit unit, 300 clips on the 8-bit unit.
    do_reset(1'b0);
    set_sig(1'b0, 2);
    set_sig(1'b1, 20);
    set_sig(1'b0, 3);
    set_sig(1'b1, 5);
    set_sig(1'b0, 3);
    set_sig(1'b1, 300);
    set_sig(1'b0, 3);
    exp_hi4_q = '{9'h10f, 9'h005, 9'h10f};
    exp_lo4_q = '{9'h003, 9'h003};
    exp_hi8_q = '{9'h014, 9'h005, 9'h1ff};
    exp_lo8_q = '{9'h003, 9'h003};
    end_scn("saturate");

    // Alternating one-cycle high / one-cycle low.
    do_reset(1'b0);
    set_sig(1'b0, 1);
    repeat (8) begin
      set_sig(1'b1, 1);
      set_sig(1'b0, 1);
    end
    repeat (8) push_hi(1);
    repeat (7) push_lo(1);
    end_scn("alternate");

    // Reset in the middle of a high interval.
    set_sig(1'b0, 2);
    set_sig(1'b1, 6);
    @(negedge clk);
    #1;
    check_lit("midrst busy before", int'(bus8.busy), 1);
    check_lit("midrst hi_width before", int'(bus8.hi_width), 1);
    rst = 1'b1;
    #1;
    check_lit("midrst busy", int'(bus8.busy), 0);
    check_lit("midrst hi_width", int'(bus8.hi_width), 0);
    check_lit("midrst lo_width", int'(bus8.lo_width), 0);
    check_lit("midrst state", int'(bus8.state_dbg), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    clear_q();
    set_sig(1'b1, 2);
    set_sig(1'b0, 2);
    set_sig(1'b1, 3);
    set_sig(1'b0, 2);
    push_hi(3);
    end_scn("midrst");

    // Randomized intervals with occasional long runs and asynchronous resets.
    do_reset(1'($urandom_range(0, 1)));
    lvl = 1'($urandom_range(0, 1));
    for (int k = 0; k < 60; k++) begin
      len = ($urandom_range(0, 15) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 10);
      set_sig(lvl, len);
      lvl = ~lvl;
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
